lut_edge_multi: RTL and testbench

LUT_EDGE_MULTI -- requirements
Module: lut_edge_multi

---
 rtl/lut_edge_multi.sv | 88 ++++++++
 tb/tb_lut_edge_multi.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/lut_edge_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lut_edge_multi
// Brief    : N-input LUT with per-input level/edge qualification and a
//            retriggerable output pulse stretcher.
// Revision : 1.0 - initial release
// ============================================================================
module lut_edge_multi #(
    parameter  int N_INP     = 5,
    parameter  int STRETCH_W = 16,
    localparam int LUT_W     = 1 << N_INP
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [N_INP-1:0]       inp_i,
    input  logic [LUT_W-1:0]       FUNC,
    input  logic                   FUNC_WSTB,
    input  logic [2*N_INP-1:0]     EDGE,
    input  logic                   EDGE_WSTB,
    input  logic [STRETCH_W-1:0]   WIDTH,
    output logic                   out_o
);

    localparam logic [1:0] c_MODE_LEVEL   = 2'd0;
    localparam logic [1:0] c_MODE_RISING  = 2'd1;
    localparam logic [1:0] c_MODE_FALLING = 2'd2;

    logic [LUT_W-1:0]     func_q;
    logic [2*N_INP-1:0]   edge_q;
    logic [N_INP-1:0]     inp_d_q;
    logic                 primed_q;
    logic [STRETCH_W-1:0] cnt_q;
    logic [STRETCH_W-1:0] cnt_d;
    logic                 out_q;
    logic                 out_d;

    logic [N_INP-1:0]     w_eff;
    logic                 w_raw;

    // Edge modes stay quiet until inp_d_q holds a real sample after reset.
    always_comb begin
        w_eff = '0;
        for (int k = 0; k < N_INP; k++) begin
            case (edge_q[2*k +: 2])
                c_MODE_LEVEL:   w_eff[k] = inp_i[k];
                c_MODE_RISING:  w_eff[k] = primed_q & inp_i[k] & ~inp_d_q[k];
                c_MODE_FALLING: w_eff[k] = primed_q & ~inp_i[k] & inp_d_q[k];
                default:        w_eff[k] = primed_q & (inp_i[k] ^ inp_d_q[k]);
            endcase
        end
    end

    assign w_raw = func_q[w_eff];

    // WIDTH is sampled only at a load, so changes mid-count never disturb it.
    always_comb begin
        cnt_d = cnt_q;
        if (w_raw) begin
            cnt_d = (WIDTH > STRETCH_W'(1)) ? (WIDTH - STRETCH_W'(1)) : '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - STRETCH_W'(1);
        end
        out_d = w_raw | (cnt_q != '0);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            func_q   <= '0;
            edge_q   <= '0;
            inp_d_q  <= '0;
            primed_q <= 1'b0;
            cnt_q    <= '0;
            out_q    <= 1'b0;
        end else begin
            if (FUNC_WSTB) func_q <= FUNC;
            if (EDGE_WSTB) edge_q <= EDGE;
            inp_d_q  <= inp_i;
            primed_q <= 1'b1;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
        end
    end

    assign out_o = out_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_edge_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lut_edge_multi
// Brief    : Scoreboard bench for lut_edge_multi (5-input and 2-input builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lut_edge_multi;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  inp = '0;
    logic [31:0] func = '0;
    logic        fstb = 1'b0;
    logic [9:0]  edg = '0;
    logic        estb = 1'b0;
    logic [15:0] width = '0;
    logic        out;

    logic [1:0]  s_inp = '0;
    logic        s_fstb = 1'b0;
    logic        s_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lut_edge_multi #(.N_INP(5), .STRETCH_W(16)) u_dut (
        .clk_i(clk), .reset_n_i(rst_n), .inp_i(inp),
        .FUNC(func), .FUNC_WSTB(fstb), .EDGE(edg), .EDGE_WSTB(estb),
        .WIDTH(width), .out_o(out)
    );

    lut_edge_multi #(.N_INP(2), .STRETCH_W(16)) u_small (
        .clk_i(clk), .reset_n_i(rst_n), .inp_i(s_inp),
        .FUNC(4'h8), .FUNC_WSTB(s_fstb), .EDGE(4'h0), .EDGE_WSTB(1'b0),
        .WIDTH(16'd0), .out_o(s_out)
    );

    // Reference model: the output is high while the current cycle lies within
    // max(W,1) cycles of the most recent LUT hit (W taken at that hit).
    logic [31:0] m_func = '0;
    logic [9:0]  m_edge = '0;
    logic [4:0]  m_prev = '0;
    logic        m_primed = 1'b0;
    int          cyc = 0;
    int          hold_until = -1;
    logic [3:0]  s_m_func = '0;
    logic        s_need_load = 1'b1;

    logic exp_q[$];
    logic s_exp_q[$];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0)   chk("out_o", out, exp_q.pop_front());
        if (s_exp_q.size() != 0) chk("small_out_o", s_out, s_exp_q.pop_front());
    end

    // Called at a falling edge; applies one cycle of stimulus and returns at the next.
    task automatic step(input logic [4:0] a_inp, input logic fs, input logic [31:0] f,
                        input logic es, input logic [9:0] e, input logic [15:0] w);
        logic [4:0] ev;
        logic [1:0] mode;
        inp = a_inp; fstb = fs; func = f; estb = es; edg = e; width = w;
        for (int k = 0; k < 5; k++) begin
            mode = m_edge[2*k +: 2];
            case (mode)
                2'd0:    ev[k] = a_inp[k];
                2'd1:    ev[k] = m_primed && a_inp[k] && !m_prev[k];
                2'd2:    ev[k] = m_primed && !a_inp[k] && m_prev[k];
                default: ev[k] = m_primed && (a_inp[k] != m_prev[k]);
            endcase
        end
        if (m_func[ev]) hold_until = cyc + ((w == 16'd0) ? 1 : int'(w)) - 1;
        exp_q.push_back(cyc <= hold_until);
        m_prev = a_inp;
        m_primed = 1'b1;
        if (fs) m_func = f;
        if (es) m_edge = e;

        s_inp = 2'($urandom);
        s_fstb = s_need_load;
        s_exp_q.push_back(s_m_func[s_inp]);
        if (s_need_load) s_m_func = 4'h8;
        s_need_load = 1'b0;

        cyc++;
        @(negedge clk);
    endtask

    task automatic hold(input logic [4:0] a_inp, input int n, input logic [15:0] w);
        for (int i = 0; i < n; i++) step(a_inp, 1'b0, 32'h0, 1'b0, 10'h0, w);
    endtask

    // Asserts reset between clock edges and expects the output to drop at once.
    task automatic do_reset(input int n);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_async_out", out, 1'b0);
        chk("reset_async_small_out", s_out, 1'b0);
        m_func = '0; m_edge = '0; m_prev = '0; m_primed = 1'b0;
        hold_until = cyc - 1;
        s_m_func = '0; s_need_load = 1'b1;
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        chk("reset_out", out, 1'b0);
        chk("reset_small_out", s_out, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Level pass-through on input A
        step(5'h00, 1'b1, 32'hFFFF0000, 1'b1, 10'h000, 16'd0);
        hold(5'h00, 1, 0); hold(5'h10, 2, 0); hold(5'h00, 2, 0);
        // Rising edge, held high
        step(5'h00, 1'b0, 32'h0, 1'b1, 10'h100, 16'd0);
        hold(5'h10, 5, 0); hold(5'h00, 3, 0);
        // Either edge
        step(5'h00, 1'b0, 32'h0, 1'b1, 10'h300, 16'd0);
        hold(5'h10, 3, 0); hold(5'h00, 3, 0);
        // Stretch with retrigger
        step(5'h00, 1'b0, 32'h0, 1'b1, 10'h100, 16'd4);
        hold(5'h10, 1, 4); hold(5'h00, 1, 4); hold(5'h10, 1, 4); hold(5'h00, 8, 4);
        // WIDTH=1 behaves like WIDTH=0
        hold(5'h10, 1, 1); hold(5'h00, 3, 1);
        // WIDTH change during a count
        hold(5'h10, 1, 10); hold(5'h00, 3, 2); hold(5'h00, 9, 2);
        // All-zero FUNC lets the running stretch finish
        hold(5'h10, 1, 6); step(5'h00, 1'b1, 32'h0, 1'b0, 10'h0, 16'd6);
        hold(5'h10, 2, 6); hold(5'h00, 7, 6);
        // Strobe latency from an all-zero table
        hold(5'h0A, 3, 0);
        step(5'h0A, 1'b1, 32'hFFFFFFFF, 1'b0, 10'h0, 16'd0);
        hold(5'h0A, 3, 0);
        // Edge mode selected while the input is stable high
        step(5'h10, 1'b1, 32'hFFFF0000, 1'b1, 10'h000, 16'd0);
        hold(5'h10, 2, 0);
        step(5'h10, 1'b0, 32'h0, 1'b1, 10'h100, 16'd0);
        hold(5'h10, 4, 0);
        // Reset in the middle of a long stretch, A held high across release
        hold(5'h00, 1, 100); hold(5'h10, 10, 100);
        do_reset(2);
        step(5'h10, 1'b1, 32'hFFFF0000, 1'b1, 10'h100, 16'd0);
        hold(5'h10, 6, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(5'($urandom), ($urandom_range(0, 7) == 0), $urandom,
                 ($urandom_range(0, 7) == 0), 10'($urandom),
                 16'(($urandom_range(0, 9) == 0) ? $urandom_range(7, 40) : $urandom_range(0, 6)));
            if (i == 200) begin
                do_reset(1);
            end
        end

        fstb = 1'b0; estb = 1'b0; s_fstb = 1'b0;
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0 || s_exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size() + s_exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
